// File: rtl/modulo_pkg.sv
// Shared types and the conditional-subtract remainder step for the mod-N serializer/detector pair.
package modulo_pkg;

   localparam int unsigned MODULUS_DEFAULT = 5;
   localparam int unsigned REM_W           = 3;
   localparam int unsigned STEP_W          = REM_W + 1;

   typedef logic [REM_W-1:0] rem_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FLUSH
   } ser_state_t;

   // (2r + b) mod modulus; r < modulus keeps 2r + b below 2*modulus, so one subtract suffices
   function automatic rem_t rem_step(input rem_t r, input logic b, input int unsigned modulus);
      logic [STEP_W-1:0] w_t;
      w_t = {r, b};
      if (w_t >= STEP_W'(modulus)) begin
         w_t = w_t - STEP_W'(modulus);
      end
      return w_t[REM_W-1:0];
   endfunction

endpackage

// File: rtl/modulo_stream_serializer_if.sv
// Word-in / bitstream-out bundle of the mod-N stream serializer.
interface modulo_stream_serializer_if #(
   parameter int unsigned WIDTH = 8
);

   logic                 in_valid;
   logic [WIDTH-1:0]     in_data;
   logic                 in_ready;
   logic                 serial_bit;
   logic                 bit_valid;
   logic                 frame_start;
   logic                 frame_end;
   modulo_pkg::rem_t     final_rem;
   logic                 rem_valid;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  serial_bit,
      input  bit_valid,
      input  frame_start,
      input  frame_end,
      input  final_rem,
      input  rem_valid
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output serial_bit,
      output bit_valid,
      output frame_start,
      output frame_end,
      output final_rem,
      output rem_valid
   );

endinterface

// File: rtl/modulo_rem_accum.sv
// Registered running remainder of an MSB-first bitstream; clear wins over step.
module modulo_rem_accum
   import modulo_pkg::*;
#(
   parameter int unsigned MODULUS = MODULUS_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_step,
   input  logic i_bit,
   output rem_t o_rem
);

   rem_t r_rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem <= '0;
      end else if (i_clear) begin
         r_rem <= '0;
      end else if (i_step) begin
         r_rem <= rem_step(r_rem, i_bit, MODULUS);
      end
   end

   assign o_rem = r_rem;

endmodule

// File: rtl/modulo_stream_serializer.sv
// Serialises accepted words MSB-first with frame strobes and reports word mod MODULUS per frame.
// MODSER_BACKTOBACK_EN: accept the next word on the frame_end cycle and skip FLUSH (zero-gap stream).
module modulo_stream_serializer
   import modulo_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MODULUS = MODULUS_DEFAULT
) (
   input  logic                       clock,
   input  logic                       reset,
   modulo_stream_serializer_if.slave  bus
);

   localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifdef MODSER_BACKTOBACK_EN
   localparam logic BTB = 1'b1;
`else
   localparam logic BTB = 1'b0;
`endif

   ser_state_t        r_state;
   logic [WIDTH-1:0]  r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_in_ready;
   logic              r_serial_bit;
   logic              r_bit_valid;
   logic              r_frame_start;
   logic              r_frame_end;
   logic              r_rem_valid;
   rem_t              r_final_rem;

   logic              w_accept;
   logic              w_last;
   logic              w_step;
   logic [CNT_W-1:0]  w_cnt_nxt;
   rem_t              w_rem;
   rem_t              w_rem_done;

   assign w_accept   = bus.in_valid && r_in_ready;
   assign w_last     = (r_state == SHIFT) && (r_cnt == LAST);
   assign w_step     = (r_state == SHIFT);
   assign w_cnt_nxt  = r_cnt + 1'b1;
   // remainder including the bit on the wire this cycle
   assign w_rem_done = rem_step(w_rem, r_serial_bit, MODULUS);

   modulo_rem_accum #(
      .MODULUS (MODULUS)
   ) u_accum (
      .clk     (clock),
      .rst_n   (reset),
      .i_clear (w_accept),
      .i_step  (w_step),
      .i_bit   (r_serial_bit),
      .o_rem   (w_rem)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_cnt         <= '0;
         r_in_ready    <= 1'b1;
         r_serial_bit  <= 1'b0;
         r_bit_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_rem_valid   <= 1'b0;
         r_final_rem   <= '0;
      end else begin
         r_rem_valid <= 1'b0;
         if (w_accept) begin
            // new frame: k=0 bit goes out next cycle
            r_state       <= SHIFT;
            r_shift       <= bus.in_data << 1;
            r_serial_bit  <= bus.in_data[WIDTH-1];
            r_cnt         <= '0;
            r_bit_valid   <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_end   <= (LAST == '0);
            r_in_ready    <= BTB && (LAST == '0);
            if (w_last) begin
               r_final_rem <= w_rem_done;
               r_rem_valid <= 1'b1;
            end
         end else begin
            case (r_state)
               SHIFT: begin
                  if (w_last) begin
                     r_state       <= FLUSH;
                     r_serial_bit  <= 1'b0;
                     r_bit_valid   <= 1'b0;
                     r_frame_start <= 1'b0;
                     r_frame_end   <= 1'b0;
                     r_in_ready    <= 1'b0;
                     r_final_rem   <= w_rem_done;
                     r_rem_valid   <= 1'b1;
                  end else begin
                     r_cnt         <= w_cnt_nxt;
                     r_shift       <= r_shift << 1;
                     r_serial_bit  <= r_shift[WIDTH-1];
                     r_frame_start <= 1'b0;
                     r_frame_end   <= (w_cnt_nxt == LAST);
                     r_in_ready    <= BTB && (w_cnt_nxt == LAST);
                  end
               end
               FLUSH: begin
                  r_state    <= IDLE;
                  r_in_ready <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.serial_bit  = r_serial_bit;
   assign bus.bit_valid   = r_bit_valid;
   assign bus.frame_start = r_frame_start;
   assign bus.frame_end   = r_frame_end;
   assign bus.final_rem   = r_final_rem;
   assign bus.rem_valid   = r_rem_valid;

endmodule

// File: tb/tb_modulo_stream_serializer.sv
// Self-checking bench for modulo_stream_serializer: directed frames, full sweep, backpressure, mid-frame reset.
`timescale 1ns/1ps
module tb_modulo_stream_serializer;
   import modulo_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int          MOD   = 5;
`ifdef MODSER_BACKTOBACK_EN
   localparam int   SPACING = 8;
   localparam logic BTB     = 1'b1;
`else
   localparam int   SPACING = 10;
   localparam logic BTB     = 1'b0;
`endif

   typedef struct packed {
      logic b;
      logic first;
      logic last;
   } bit_exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   bit_exp_t exp_bits[$];
   int       exp_rems[$];

   modulo_stream_serializer_if #(.WIDTH(WIDTH)) bus ();

   modulo_stream_serializer #(
      .WIDTH   (WIDTH),
      .MODULUS (MOD)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic void push_frame(input logic [WIDTH-1:0] w);
      for (int k = 0; k < int'(WIDTH); k++) begin
         bit_exp_t e;
         e.b     = w[WIDTH-1-k];
         e.first = (k == 0);
         e.last  = (k == int'(WIDTH) - 1);
         exp_bits.push_back(e);
      end
      exp_rems.push_back(int'(w) % MOD);
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (2) @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      checks++;
      if ({bus.serial_bit, bus.bit_valid, bus.frame_start, bus.frame_end, bus.rem_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000",
                  {bus.serial_bit, bus.bit_valid, bus.frame_start, bus.frame_end, bus.rem_valid});
      end
      checks++;
      if (bus.final_rem !== rem_t'(0)) begin
         errors++;
         $display("FAIL reset_final_rem: got %0d expected 0", bus.final_rem);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.bit_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got ready=%b valid=%b expected ready=1 valid=0",
                  bus.in_ready, bus.bit_valid);
      end
   endtask

   task automatic test_single(input logic [WIDTH-1:0] w);
      rem_t exp_rem;
      exp_rem = rem_t'(int'(w) % MOD);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_idle_ready w=%h: got %b expected 1", w, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      @(negedge clock);
      bus.in_valid = 1'b0;
      bus.in_data  = ~w;
      for (int c = 1; c <= int'(WIDTH) + 2; c++) begin
         logic exp_rdy;
         if (c <= int'(WIDTH)) begin
            checks++;
            if ({bus.bit_valid, bus.serial_bit, bus.frame_start, bus.frame_end} !==
                {1'b1, w[int'(WIDTH) - c], (c == 1), (c == int'(WIDTH))}) begin
               errors++;
               $display("FAIL single_bit w=%h c=%0d: got vld/bit/fs/fe=%b expected %b", w, c,
                        {bus.bit_valid, bus.serial_bit, bus.frame_start, bus.frame_end},
                        {1'b1, w[int'(WIDTH) - c], (c == 1), (c == int'(WIDTH))});
            end
            exp_rdy = BTB && (c == int'(WIDTH));
         end else if (c == int'(WIDTH) + 1) begin
            checks++;
            if ({bus.bit_valid, bus.rem_valid, bus.final_rem} !== {1'b0, 1'b1, exp_rem}) begin
               errors++;
               $display("FAIL single_rem w=%h: got vld=%b rv=%b rem=%0d expected vld=0 rv=1 rem=%0d",
                        w, bus.bit_valid, bus.rem_valid, bus.final_rem, exp_rem);
            end
            exp_rdy = 1'b0;
         end else begin
            checks++;
            if ({bus.bit_valid, bus.rem_valid, bus.final_rem} !== {1'b0, 1'b0, exp_rem}) begin
               errors++;
               $display("FAIL single_hold w=%h: got vld=%b rv=%b rem=%0d expected vld=0 rv=0 rem=%0d",
                        w, bus.bit_valid, bus.rem_valid, bus.final_rem, exp_rem);
            end
            exp_rdy = 1'b1;
         end
         checks++;
         if (bus.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL single_ready w=%h c=%0d: got %b expected %b", w, c, bus.in_ready, exp_rdy);
         end
         if (c < int'(WIDTH) + 2) @(negedge clock);
      end
   endtask

   task automatic test_sweep();
      int       x = 0;
      int       cyc = 0;
      int       last_start = -1;
      bit_exp_t e;
      int       er;
      while ((x < 256 || exp_bits.size() != 0 || exp_rems.size() != 0) &&
             cyc < 256 * (SPACING + 2) + 50) begin
         if (bus.bit_valid === 1'b1) begin
            checks++;
            if (exp_bits.size() == 0) begin
               errors++;
               $display("FAIL sweep_extra_bit cyc=%0d: got bit %b expected none", cyc, bus.serial_bit);
            end else begin
               e = exp_bits.pop_front();
               if ({bus.serial_bit, bus.frame_start, bus.frame_end} !== {e.b, e.first, e.last}) begin
                  errors++;
                  $display("FAIL sweep_bit cyc=%0d: got bit/fs/fe=%b expected %b", cyc,
                           {bus.serial_bit, bus.frame_start, bus.frame_end}, {e.b, e.first, e.last});
               end
            end
         end
         if (bus.rem_valid === 1'b1) begin
            checks++;
            if (exp_rems.size() == 0) begin
               errors++;
               $display("FAIL sweep_extra_rem cyc=%0d: got %0d expected none", cyc, bus.final_rem);
            end else begin
               er = exp_rems.pop_front();
               if (bus.final_rem !== rem_t'(er)) begin
                  errors++;
                  $display("FAIL sweep_rem cyc=%0d: got %0d expected %0d", cyc, bus.final_rem, er);
               end
            end
         end
         if (bus.frame_start === 1'b1) begin
            if (last_start >= 0) begin
               checks++;
               if (cyc - last_start != SPACING) begin
                  errors++;
                  $display("FAIL sweep_spacing cyc=%0d: got %0d expected %0d", cyc, cyc - last_start, SPACING);
               end
            end
            last_start = cyc;
         end
         if (x < 256) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(x);
            if (bus.in_ready === 1'b1) begin
               push_frame(8'(x));
               x++;
            end
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clock);
         cyc++;
      end
      checks++;
      if (x != 256 || exp_bits.size() != 0 || exp_rems.size() != 0) begin
         errors++;
         $display("FAIL sweep_incomplete: got words=%0d bits_left=%0d rems_left=%0d expected 256/0/0",
                  x, exp_bits.size(), exp_rems.size());
      end
   endtask

   task automatic test_backpressure();
      int       cyc = 0;
      int       accepts = 0;
      bit_exp_t e;
      int       er;
      for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_idle_ready: got %b expected 1", bus.in_ready);
      end
      push_frame(8'h12);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h12;
      while ((exp_bits.size() != 0 || exp_rems.size() != 0) && cyc < 60) begin
         if (bus.bit_valid === 1'b1) begin
            checks++;
            if (exp_bits.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_bit cyc=%0d: got bit %b expected none", cyc, bus.serial_bit);
            end else begin
               e = exp_bits.pop_front();
               if ({bus.serial_bit, bus.frame_start, bus.frame_end} !== {e.b, e.first, e.last}) begin
                  errors++;
                  $display("FAIL bp_bit cyc=%0d: got bit/fs/fe=%b expected %b", cyc,
                           {bus.serial_bit, bus.frame_start, bus.frame_end}, {e.b, e.first, e.last});
               end
            end
         end
         if (bus.rem_valid === 1'b1) begin
            checks++;
            if (exp_rems.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_rem cyc=%0d: got %0d expected none", cyc, bus.final_rem);
            end else begin
               er = exp_rems.pop_front();
               if (bus.final_rem !== rem_t'(er)) begin
                  errors++;
                  $display("FAIL bp_rem cyc=%0d: got %0d expected %0d", cyc, bus.final_rem, er);
               end
            end
         end
         if (accepts == 2) bus.in_valid = 1'b0;
         if (cyc == 3) begin
            bus.in_data = 8'h34;
            push_frame(8'h34);
         end
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            accepts++;
            if (accepts == 2) begin
               checks++;
               if (cyc != SPACING) begin
                  errors++;
                  $display("FAIL bp_accept_cycle: got %0d expected %0d", cyc, SPACING);
               end
            end
         end
         @(negedge clock);
         cyc++;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (accepts != 2 || exp_bits.size() != 0 || exp_rems.size() != 0) begin
         errors++;
         $display("FAIL bp_done: got accepts=%0d bits_left=%0d rems_left=%0d expected 2/0/0",
                  accepts, exp_bits.size(), exp_rems.size());
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_idle_ready: got %b expected 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      @(negedge clock);
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clock);
      checks++;
      if ({bus.bit_valid, bus.serial_bit, bus.frame_start} !== 3'b110) begin
         errors++;
         $display("FAIL mid_k4: got vld/bit/fs=%b expected 110",
                  {bus.bit_valid, bus.serial_bit, bus.frame_start});
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.serial_bit, bus.bit_valid, bus.frame_start, bus.frame_end, bus.rem_valid,
           bus.final_rem, bus.in_ready} !== {5'b0, 3'b000, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b expected 000000001",
                  {bus.serial_bit, bus.bit_valid, bus.frame_start, bus.frame_end, bus.rem_valid,
                   bus.final_rem, bus.in_ready});
      end
      @(negedge clock);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if ({bus.rem_valid, bus.bit_valid, bus.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL mid_after_release: got rv/vld/rdy=%b expected 001",
                     {bus.rem_valid, bus.bit_valid, bus.in_ready});
         end
      end
      test_single(8'h05);
   endtask

   initial begin
      test_reset();
      test_single(8'h07);
      test_single(8'hFF);
      test_single(8'h80);
      test_sweep();
      test_backpressure();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/modulo_stream_serializer.md
Name: modulo_stream_serializer

Overview:
- Transmit-side counterpart of the mod-5 serial detector.
- Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first as a serial bitstream (`serial_bit`/`bit_valid`) with frame strobes.
- Computes the golden remainder (word mod MODULUS) alongside the stream, so the detector can be driven and checked directly.

Parameters:
- WIDTH, 8: input word width in bits.
- MODULUS, 5: divisor for the reference remainder. Must be ≥2 and ≤2**REM_W.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- in_valid  in  1  producer has a word on `in_data`.
- in_data  in  WIDTH  word to serialise.
- in_ready  out  1  block can accept a word this cycle.
- serial_bit  out  1  current stream bit, MSB first.
- bit_valid  out  1  `serial_bit` is meaningful this cycle.
- frame_start  out  1  high with the first (MSB) bit of a frame.
- frame_end  out  1  high with the last (LSB) bit of a frame.
- final_rem  out  REM_W  remainder of the last completed frame, (in_data mod MODULUS).
- rem_valid  out  1  one-cycle pulse when `final_rem` updates.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, `in_ready`=1.
  - `serial_bit`, `bit_valid`, `frame_start`, `frame_end`, `rem_valid` = 0.
  - `final_rem` = 0; shift register, bit counter and running remainder = 0.
- States: IDLE, SHIFT, FLUSH.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready` at a clock edge: latch `in_data`, clear running remainder, go to SHIFT.
  - The first bit appears the cycle after acceptance (latency 1).
- SHIFT: lasts exactly WIDTH cycles; `bit_valid`=1 throughout.
  - Cycle k (k=0..WIDTH-1) drives `serial_bit` = latched bit [WIDTH-1-k].
  - `frame_start`=1 on k=0 only; `frame_end`=1 on k=WIDTH-1 only.
  - `in_ready`=0 during SHIFT (see the optional feature for the exception).
  - Running remainder update each SHIFT cycle: r_next = (2*r + serial_bit) mod MODULUS.
    - Done by conditional subtract, no divider: 2r+b < 2*MODULUS, so subtract MODULUS at most once.
  - After k=WIDTH-1, go to FLUSH.
- FLUSH (one cycle):
  - `final_rem` <= the completed remainder; `rem_valid`=1.
  - `bit_valid`=0, `in_ready`=0.
  - Next state IDLE, so frames are separated by at least one idle bit slot. The detector consumer clears on that slot.
- `in_data` is sampled only at acceptance; later changes are ignored.
- `in_valid` high while `in_ready`=0: no acceptance, no state change. The word stays pending until `in_ready`.
- Reset mid-frame: the frame is abandoned immediately; `final_rem` is not updated and there is no `rem_valid` pulse.
- `final_rem` holds its value between pulses.

Optional Feature:
- Macro: MODSER_BACKTOBACK_EN.
- Defined:
  - `in_ready`=1 also during the SHIFT cycle with `frame_end`=1.
  - If a word is accepted there, the next cycle goes straight to SHIFT k=0 with `frame_start`=1; FLUSH is skipped.
  - `final_rem`/`rem_valid` update in that same cycle from the completed remainder. The running remainder is cleared for the new frame.
  - Result is a zero-gap stream.
- Not defined: behaviour exactly as above, with a mandatory FLUSH gap between frames.

Decomposition:
- Package `modulo_pkg`:
  - `localparam MODULUS_DEFAULT=5`, `REM_W=3`.
  - `typedef logic [REM_W-1:0] rem_t`.
  - `typedef enum {IDLE, SHIFT, FLUSH} ser_state_t`.
  - `function rem_step(rem_t r, logic b)`, implementing the conditional-subtract update. This function is shared with the detector.
- Sub-module `modulo_rem_accum`:
  - Registered running remainder with `clear`/`step` inputs.
  - Reused by the detector and the bench scoreboard.

Test Plan:
- Accept 8'h07 -> `serial_bit` sequence 0,0,0,0,0,1,1,1 over 8 cycles.
  - `frame_start` on cycle 1, `frame_end` on cycle 8.
  - `rem_valid` on cycle 9 with `final_rem`=2.
- Accept 8'hFF -> eight 1s, `final_rem`=0. Then 8'h80 -> 1 followed by seven 0s, `final_rem`=3.
- Sweep `in_data`=0..255 with `in_valid` held -> every `final_rem` == x mod 5.
  - Without the macro, frame spacing is exactly 10 cycles (1 accept-to-first-bit + 8 SHIFT + 1 FLUSH).
  - With MODSER_BACKTOBACK_EN, spacing is 8 cycles and there are no `bit_valid` gaps.
- Backpressure: change `in_data` from 8'h12 to 8'h34 mid-frame while `in_valid`=1 -> the current frame stays 8'h12; 8'h34 is accepted only when `in_ready` returns.
- Assert reset on SHIFT k=4 of 8'hAA -> all outputs 0 within the same cycle, no `rem_valid`. After release, `in_ready`=1 and a new frame 8'h05 gives `final_rem`=0.
